lcd_cmd_sequencer: RTL and testbench

Command scheduler in front of the LCD image-processing core. Buffers a stream of 4-bit host commands in a small FIFO and issues them one at a time to the core over its cmd/cmd_valid/busy handshake. Stops after the write-out command (code 0), waits for the core's done, then reports completion. Sits between the testbench/host command source and the LCD controller core.

---
 rtl/lcd_cmd_sequencer.sv | 109 ++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: FIFO-buffered host command scheduler for the LCD core, issuing one command per busy handshake.
// Optional LCD_SEQ_FILTER_EN: codes 12..15 are accepted but dropped, and flagged through overflow.
module lcd_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [7:0] issued_cnt,
    output logic       overflow,
    output logic       finished
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic          closed_q, closed_d, ovf_q, ovf_d;
    logic [3:0]    lcd_cmd_q, lcd_cmd_d;
    logic          valid_q, valid_d;
    logic [7:0]    issued_q, issued_d;
    logic          full, empty, push, store, pop, drop;

    assign full       = count_q == (AW+1)'(DEPTH);
    assign empty      = count_q == '0;
    assign host_ready = !full && !closed_q && state_q != S_DONE;
    assign push       = host_valid && host_ready;
    assign store      = push && !drop;
    assign pop        = state_q == S_IDLE && !empty && !lcd_busy;

`ifdef LCD_SEQ_FILTER_EN
    logic ill_q, ill_d;
    assign drop     = host_cmd >= 4'd12;
    assign ill_d    = ill_q || (push && drop);
    assign overflow = ovf_q || ill_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) ill_q <= 1'b0;
        else       ill_q <= ill_d;
`else
    assign drop     = 1'b0;
    assign overflow = ovf_q;
`endif

    always_comb begin
        wr_ptr_d  = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + (AW+1)'(store) - (AW+1)'(pop);
        closed_d  = closed_q || (push && host_cmd == 4'd0);
        ovf_d     = ovf_q || (host_valid && full && !closed_q);
        lcd_cmd_d = pop ? mem_q[rd_ptr_q] : lcd_cmd_q;
        valid_d   = pop;
        issued_d  = (pop && issued_q != 8'hFF) ? issued_q + 8'd1 : issued_q;
        state_d   = state_q;
        case (state_q)
            S_IDLE:  state_d = pop ? S_ISSUE : S_IDLE;
            S_ISSUE: state_d = lcd_cmd_q == 4'd0 ? S_DRAIN : S_GUARD;
            // busy is not yet valid the cycle after the strobe
            S_GUARD: state_d = S_WAIT;
            S_WAIT:  state_d = lcd_busy ? S_WAIT : S_IDLE;
            S_DRAIN: state_d = lcd_done ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (store) mem_q[wr_ptr_q] <= host_cmd;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            closed_q  <= 1'b0;
            ovf_q     <= 1'b0;
            lcd_cmd_q <= 4'd0;
            valid_q   <= 1'b0;
            issued_q  <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            closed_q  <= closed_d;
            ovf_q     <= ovf_d;
            lcd_cmd_q <= lcd_cmd_d;
            valid_q   <= valid_d;
            issued_q  <= issued_d;
        end

    assign lcd_cmd       = lcd_cmd_q;
    assign lcd_cmd_valid = valid_q;
    assign issued_cnt    = issued_q;
    assign finished      = state_q == S_DONE;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: randomized scenario bench for lcd_cmd_sequencer with a core busy model and strobe monitor.
module tb_lcd_cmd_sequencer;
`ifdef LCD_SEQ_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    logic       clk = 1'b0, reset = 1'b1;
    logic [3:0] host_cmd = 4'd0;
    logic       host_valid = 1'b0, lcd_done = 1'b0, busy_force = 1'b0;
    logic       host_ready, lcd_cmd_valid, lcd_busy, overflow, finished;
    logic [3:0] lcd_cmd;
    logic [7:0] issued_cnt;
    int         hold = 1, busy_cnt = 0, cyc = 0;
    int         checks = 0, errors = 0;
    logic [3:0] got_q[$];
    logic [3:0] exp_q[$];

    lcd_cmd_sequencer #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_valid(host_valid),
        .host_ready(host_ready), .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done), .issued_cnt(issued_cnt),
        .overflow(overflow), .finished(finished)
    );

    always #5 clk = ~clk;

    // core model: busy for `hold` cycles starting the cycle after each strobe
    assign lcd_busy = busy_force || busy_cnt != 0;
    always @(posedge clk or posedge reset)
        if (reset) busy_cnt <= 0;
        else if (lcd_cmd_valid) busy_cnt <= hold;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;

    always @(posedge clk) cyc <= cyc + 1;

    logic       prev_valid = 1'b0, prev_busy = 1'b0;
    logic [3:0] last_cmd = 4'd0;
    int         last_cyc = -1000;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0; prev_busy = lcd_busy; last_cmd = 4'd0; last_cyc = -1000;
        end else begin
            if (lcd_cmd_valid) begin
                got_q.push_back(lcd_cmd);
                checks++;
                if (prev_valid) begin errors++; $display("FAIL strobe_width valid two cycles in a row, required 1"); end
                checks++;
                if (prev_busy) begin errors++; $display("FAIL strobe_while_busy busy=1 at issue edge, required 0"); end
                checks++;
                if (cyc - last_cyc < ((hold + 3 > 4) ? hold + 3 : 4)) begin
                    errors++; $display("FAIL strobe_spacing gap %0d required >= %0d", cyc - last_cyc, (hold + 3 > 4) ? hold + 3 : 4);
                end
                last_cyc = cyc; last_cmd = lcd_cmd;
            end else begin
                checks++;
                if (lcd_cmd !== last_cmd) begin errors++; $display("FAIL cmd_hold lcd_cmd %0d required %0d", lcd_cmd, last_cmd); end
            end
            prev_valid = lcd_cmd_valid; prev_busy = lcd_busy;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(int h, logic bf);
        @(posedge clk); #1;
        reset = 1'b1; host_valid = 1'b0; lcd_done = 1'b0; busy_force = bf; hold = h;
        tick(2);
        got_q.delete(); exp_q.delete();
        reset = 1'b0;
    endtask

    // model rule: accepted codes are stored unless filtered (12..15 with filter)
    task automatic push(input logic [3:0] c, input bit force_v, output bit acc);
        int n = 0;
        if (!force_v) while (!host_ready && n < 300) begin tick(); n++; end
        if (n >= 300) begin checks++; errors++; $display("FAIL push_timeout host_ready %b required 1", host_ready); end
        host_cmd = c; host_valid = 1'b1; acc = host_ready;
        tick();
        host_valid = 1'b0;
        if (acc && !(FILT && c >= 4'd12)) exp_q.push_back(c);
    endtask

    task automatic wait_strobes(int k);
        int n = 0;
        while (got_q.size() < k && n < 500) begin tick(); n++; end
        checks++;
        if (got_q.size() < k) begin errors++; $display("FAIL strobe_timeout got %0d strobes required %0d", got_q.size(), k); end
    endtask

    task automatic test_reset();
        do_reset(1, 1'b0);
        checks += 6;
        if (host_ready !== 1'b1)     begin errors++; $display("FAIL rst_host_ready got %b want 1", host_ready); end
        if (lcd_cmd !== 4'd0)        begin errors++; $display("FAIL rst_lcd_cmd got %0d want 0", lcd_cmd); end
        if (lcd_cmd_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid got %b want 0", lcd_cmd_valid); end
        if (issued_cnt !== 8'd0)     begin errors++; $display("FAIL rst_issued got %0d want 0", issued_cnt); end
        if (overflow !== 1'b0)       begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
        if (finished !== 1'b0)       begin errors++; $display("FAIL rst_finished got %b want 0", finished); end
    endtask

    task automatic test_busy_hold();
        bit acc;
        do_reset(1, 1'b1);
        push(4'd1, 1'b0, acc); push(4'd5, 1'b0, acc); push(4'd0, 1'b0, acc);
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        tick(64);
        checks += 2;
        if (got_q.size() != 0)   begin errors++; $display("FAIL busy_no_strobe got %0d strobes want 0", got_q.size()); end
        if (issued_cnt !== 8'd0) begin errors++; $display("FAIL busy_issued got %0d want 0", issued_cnt); end
        busy_force = 1'b0;
        wait_strobes(3);
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_seq_len got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_seq[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
        end
        tick(2);
        checks += 2;
        if (issued_cnt !== 8'd3) begin errors++; $display("FAIL busy_issued_cnt got %0d want 3", issued_cnt); end
        if (finished !== 1'b0)   begin errors++; $display("FAIL early_done_ignored finished %b want 0", finished); end
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL finish_next_cycle got %b want 1", finished); end
        tick(5);
        checks += 2;
        if (finished !== 1'b1)   begin errors++; $display("FAIL finish_sticky got %b want 1", finished); end
        if (host_ready !== 1'b0) begin errors++; $display("FAIL done_host_ready got %b want 0", host_ready); end
    endtask

    task automatic test_overflow();
        bit acc;
        do_reset(1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            push(4'(i + 1), 1'b1, acc);
            checks++;
            if (acc !== (i < 8)) begin errors++; $display("FAIL ovf_accept[%0d] got %b want %b", i, acc, i < 8); end
            if (i == 7) begin
                checks += 2;
                if (host_ready !== 1'b0) begin errors++; $display("FAIL full_host_ready got %b want 0", host_ready); end
                if (overflow !== 1'b0)   begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        busy_force = 1'b0;
        wait_strobes(8);
        tick(6);
        checks += 3;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_seq_len got %0d want %0d", got_q.size(), exp_q.size()); end
        if (issued_cnt !== 8'd8) begin errors++; $display("FAIL ovf_issued got %0d want 8", issued_cnt); end
        if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_seq[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_close();
        bit acc;
        do_reset(0, 1'b0);
        push(4'd0, 1'b1, acc);
        push(4'd3, 1'b1, acc);
        checks += 2;
        if (acc !== 1'b0)      begin errors++; $display("FAIL closed_accept got %b want 0", acc); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL closed_overflow got %b want 0", overflow); end
        wait_strobes(1);
        tick(20);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 4'd0) begin errors++; $display("FAIL close_seq got %0d strobes want 1 (code 0)", got_q.size()); end
        lcd_done = 1'b1; tick(); lcd_done = 1'b0;
        checks++;
        if (finished !== 1'b1) begin errors++; $display("FAIL close_finished got %b want 1", finished); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset(30, 1'b0);
        for (int i = 1; i <= 5; i++) push(4'(i), 1'b0, acc);
        wait_strobes(1);
        tick(3);
        @(posedge clk); #2 reset = 1'b1; #1;
        checks += 4;
        if (issued_cnt !== 8'd0)    begin errors++; $display("FAIL mid_rst_issued got %0d want 0", issued_cnt); end
        if (lcd_cmd !== 4'd0)       begin errors++; $display("FAIL mid_rst_cmd got %0d want 0", lcd_cmd); end
        if (lcd_cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", lcd_cmd_valid); end
        if (host_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready got %b want 1", host_ready); end
        tick(2);
        got_q.delete(); exp_q.delete();
        reset = 1'b0;
        tick(30);
        checks += 2;
        if (got_q.size() != 0)   begin errors++; $display("FAIL mid_rst_quiet got %0d strobes want 0", got_q.size()); end
        if (issued_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", issued_cnt); end
        push(4'd7, 1'b0, acc);
        wait_strobes(1);
        tick();
        checks += 2;
        if (got_q.size() != 1 || got_q[0] !== 4'd7) begin errors++; $display("FAIL mid_rst_new got %0d strobes want one code 7", got_q.size()); end
        if (issued_cnt !== 8'd1) begin errors++; $display("FAIL mid_rst_new_cnt got %0d want 1", issued_cnt); end
    endtask

    task automatic test_filter();
        bit acc;
        do_reset(2, 1'b0);
        push(4'd2, 1'b0, acc); push(4'd13, 1'b0, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL filt_accept13 got %b want 1", acc); end
        push(4'd0, 1'b0, acc);
        wait_strobes(exp_q.size());
        tick(4);
        checks += 3;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL filt_seq_len got %0d want %0d", got_q.size(), exp_q.size()); end
        if (issued_cnt !== 8'(exp_q.size())) begin errors++; $display("FAIL filt_issued got %0d want %0d", issued_cnt, exp_q.size()); end
        if (overflow !== FILT) begin errors++; $display("FAIL filt_overflow got %b want %b", overflow, FILT); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL filt_seq[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit acc, ill;
        for (int it = 0; it < 8; it++) begin
            do_reset($urandom_range(0, 6), 1'b0);
            ill = 1'b0;
            repeat ($urandom_range(3, 14)) begin
                logic [3:0] c;
                c = 4'($urandom_range(1, 15));
                push(c, 1'b0, acc);
                checks++;
                if (acc !== 1'b1) begin errors++; $display("FAIL rnd_accept code %0d got %b want 1", c, acc); end
                if (c >= 4'd12) ill = 1'b1;
                tick($urandom_range(0, 3));
            end
            push(4'd0, 1'b0, acc);
            wait_strobes(exp_q.size());
            tick(4);
            checks += 2;
            if (issued_cnt !== 8'(exp_q.size())) begin errors++; $display("FAIL rnd_issued got %0d want %0d", issued_cnt, exp_q.size()); end
            if (overflow !== (FILT && ill)) begin errors++; $display("FAIL rnd_overflow got %b want %b", overflow, FILT && ill); end
            checks++;
            if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_seq_len got %0d want %0d", got_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_seq[%0d] got %0d want %0d", i, got_q[i], exp_q[i]); end
            end
            lcd_done = 1'b1; tick(); lcd_done = 1'b0;
            checks++;
            if (finished !== 1'b1) begin errors++; $display("FAIL rnd_finished got %b want 1", finished); end
        end
    endtask

    initial begin
        test_reset();
        test_busy_hold();
        test_overflow();
        test_close();
        test_reset_mid();
        test_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
